// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
//   - store_type / load_type encodings used by the EX->MEM path and the load/store unit
//   - skid buffer occupancy states
//   - mem_ctrl_t: the bundle of fields carried from execute to memory
package riscv_pkg;

    localparam int RV_XLEN      = 32;
    localparam int RV_REGADDR_W = 5;

    typedef enum logic [1:0] {
        ST_SB  = 2'b00,
        ST_SH  = 2'b01,
        ST_SW  = 2'b10,
        ST_RSV = 2'b11
    } store_type_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_type_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

    typedef struct packed {
        logic [RV_XLEN-1:0]      result_alu;
        logic [RV_XLEN-1:0]      op2_data;
        logic                    mem_write;
        logic                    mem_read;
        logic [1:0]              store_type;
        logic [2:0]              load_type;
        logic [RV_REGADDR_W-1:0] rd;
        logic                    reg_write;
    } mem_ctrl_t;

endpackage

// File: rtl/mem_align_chk.sv
// Combinational misalignment check for a single memory access.
// Ports:
//   addr_lo     in  2  low address bits of the effective address
//   mem_read    in  1  access is a load
//   mem_write   in  1  access is a store (takes precedence for the size lookup)
//   store_type  in  2  SB/SH/SW; reserved encoding is checked as a word
//   load_type   in  3  LB/LH/LW/LBU/LHU
//   misaligned  out 1  access size does not divide the address
// The result is not qualified by any valid; callers gate it.
module mem_align_chk
    import riscv_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [1:0] store_type,
    input  logic [2:0] load_type,
    output logic       misaligned
);

    logic st_mis;
    logic ld_mis;

    always_comb begin
        st_mis = 1'b0;
        case (store_type)
            ST_SB:   st_mis = 1'b0;
            ST_SH:   st_mis = addr_lo[0];
            default: st_mis = |addr_lo;   // SW and reserved encoding
        endcase

        ld_mis = 1'b0;
        case (load_type)
            LD_LH, LD_LHU: ld_mis = addr_lo[0];
            LD_LW:         ld_mis = |addr_lo;
            default:       ld_mis = 1'b0;
        endcase

        misaligned = 1'b0;
        if (mem_write) begin
            misaligned = st_mis;
        end else if (mem_read) begin
            misaligned = ld_mis;
        end
    end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register implemented as a 2-entry skid buffer.
// HEAD drives the memory-stage outputs; SKID catches the one op that execute
// may launch in the same cycle memory stalls, so ex_ready can be a flop.
// Ports:
//   clk, rst (async, active-low), flush (drops every held op and the incoming one)
//   ex_*        execute-side op fields with ex_valid / ex_ready handshake
//   mem_ready   memory stage consumes HEAD this cycle
//   mem_valid   HEAD holds an op
//   result_alu, op2_data, store_type, load_type, rd : raw HEAD fields
//   mem_write, mem_read, reg_write : HEAD controls gated by mem_valid
//   misaligned  HEAD access is misaligned (gated by mem_valid and read|write)
module ex_mem_skid_reg
    import riscv_pkg::*;
#(
    parameter int XLEN      = RV_XLEN,
    parameter int REGADDR_W = RV_REGADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [XLEN-1:0]      ex_result_alu,
    input  logic [XLEN-1:0]      ex_op2_data,
    input  logic                 ex_mem_write,
    input  logic                 ex_mem_read,
    input  logic [1:0]           ex_store_type,
    input  logic [2:0]           ex_load_type,
    input  logic [REGADDR_W-1:0] ex_rd,
    input  logic                 ex_reg_write,
    input  logic                 mem_ready,
    output logic                 mem_valid,
    output logic [XLEN-1:0]      result_alu,
    output logic [XLEN-1:0]      op2_data,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic [1:0]           store_type,
    output logic [2:0]           load_type,
    output logic [REGADDR_W-1:0] rd,
    output logic                 reg_write,
    output logic                 misaligned
);

    // The entry type comes from the shared package, so widths must agree with it.
    if (XLEN != RV_XLEN || REGADDR_W != RV_REGADDR_W) begin : g_width_chk
        $error("ex_mem_skid_reg: XLEN/REGADDR_W must match riscv_pkg");
    end

    skid_state_e state_q, state_d;
    mem_ctrl_t   head_q, head_d;
    mem_ctrl_t   skid_q, skid_d;
    logic        ex_ready_q, ex_ready_d;
    mem_ctrl_t   ex_op;
    logic        xfer_in;
    logic        xfer_out;
    logic        head_mis;

    always_comb begin
        ex_op            = '0;
        ex_op.result_alu = ex_result_alu;
        ex_op.op2_data   = ex_op2_data;
        ex_op.mem_write  = ex_mem_write;
        ex_op.mem_read   = ex_mem_read;
        ex_op.store_type = ex_store_type;
        ex_op.load_type  = ex_load_type;
        ex_op.rd         = ex_rd;
        ex_op.reg_write  = ex_reg_write;
    end

    assign mem_valid = (state_q != SKID_EMPTY);
    assign xfer_in   = ex_valid & ex_ready_q;
    assign xfer_out  = mem_valid & mem_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // Redirect: everything held and anything arriving now is dead.
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (xfer_in) begin
                        head_d  = ex_op;
                        state_d = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (xfer_in && xfer_out) begin
                        head_d = ex_op;
                    end else if (xfer_in) begin
                        skid_d  = ex_op;
                        state_d = SKID_FULL;
                    end else if (xfer_out) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    // ex_ready is low here, so only the drain path exists.
                    if (xfer_out) begin
                        head_d  = skid_q;
                        state_d = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
        // Registered ready: low exactly while the skid entry is occupied.
        ex_ready_d = (state_d != SKID_FULL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SKID_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            ex_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            ex_ready_q <= ex_ready_d;
        end
    end

    mem_align_chk u_align (
        .addr_lo    (head_q.result_alu[1:0]),
        .mem_read   (head_q.mem_read),
        .mem_write  (head_q.mem_write),
        .store_type (head_q.store_type),
        .load_type  (head_q.load_type),
        .misaligned (head_mis)
    );

    assign ex_ready   = ex_ready_q;
    assign result_alu = head_q.result_alu;
    assign op2_data   = head_q.op2_data;
    assign store_type = head_q.store_type;
    assign load_type  = head_q.load_type;
    assign rd         = head_q.rd;
    // Bubbles must never reach data memory or the register file.
    assign mem_write  = mem_valid & head_q.mem_write;
    assign mem_read   = mem_valid & head_q.mem_read;
    assign reg_write  = mem_valid & head_q.reg_write;
    assign misaligned = mem_valid & (head_q.mem_read | head_q.mem_write) & head_mis;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_result_alu;
    logic [XLEN-1:0] ex_op2_data;
    logic            ex_mem_write;
    logic            ex_mem_read;
    logic [1:0]      ex_store_type;
    logic [2:0]      ex_load_type;
    logic [RW-1:0]   ex_rd;
    logic            ex_reg_write;
    logic            mem_ready;
    logic            mem_valid;
    logic [XLEN-1:0] result_alu;
    logic [XLEN-1:0] op2_data;
    logic            mem_write;
    logic            mem_read;
    logic [1:0]      store_type;
    logic [2:0]      load_type;
    logic [RW-1:0]   rd;
    logic            reg_write;
    logic            misaligned;

    ex_mem_skid_reg #(.XLEN(XLEN), .REGADDR_W(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result_alu(ex_result_alu), .ex_op2_data(ex_op2_data),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read),
        .ex_store_type(ex_store_type), .ex_load_type(ex_load_type),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .mem_ready(mem_ready), .mem_valid(mem_valid),
        .result_alu(result_alu), .op2_data(op2_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .store_type(store_type), .load_type(load_type),
        .rd(rd), .reg_write(reg_write), .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        w;
        logic        r;
        logic [1:0]  st;
        logic [2:0]  lt;
        logic [4:0]  rd;
        logic        rw;
    } op_t;

    // Reference model: FIFO of ops the buffer currently owns, plus the ready it advertises.
    op_t q[$];
    bit  m_ready;
    int  checks;
    int  errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from the ISA rules; misaligned when the address is not a multiple.
    function automatic bit exp_mis(input op_t o);
        int sz;
        if (o.w)      sz = (o.st == 2'd0) ? 1 : (o.st == 2'd1) ? 2 : 4;
        else if (o.r) sz = (o.lt[1:0] == 2'd0) ? 1 : (o.lt[1:0] == 2'd1) ? 2 : 4;
        else          return 1'b0;
        return (o.addr % sz) != 0;
    endfunction

    function automatic op_t mk(input logic [31:0] a, input bit w, input bit r,
                               input logic [1:0] st, input logic [2:0] lt);
        op_t o;
        o.addr = a; o.data = $urandom; o.w = w; o.r = r; o.st = st; o.lt = lt;
        o.rd = 5'($urandom); o.rw = r | (!w && !r);
        return o;
    endfunction

    function automatic op_t rand_op();
        logic [2:0] lts[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        int k = $urandom_range(0, 2);
        return mk($urandom, k == 0, k == 1, 2'($urandom), lts[$urandom_range(0, 4)]);
    endfunction

    task automatic drive(input op_t o, input bit v, input bit mr, input bit fl);
        ex_valid      = v;
        ex_result_alu = o.addr;
        ex_op2_data   = o.data;
        ex_mem_write  = o.w;
        ex_mem_read   = o.r;
        ex_store_type = o.st;
        ex_load_type  = o.lt;
        ex_rd         = o.rd;
        ex_reg_write  = o.rw;
        mem_ready     = mr;
        flush         = fl;
    endtask

    task automatic compare();
        check("ex_ready", ex_ready, m_ready);
        check("mem_valid", mem_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("result_alu", result_alu, q[0].addr);
            check("op2_data", op2_data, q[0].data);
            check("store_type", store_type, q[0].st);
            check("load_type", load_type, q[0].lt);
            check("rd", rd, q[0].rd);
            check("mem_write", mem_write, q[0].w);
            check("mem_read", mem_read, q[0].r);
            check("reg_write", reg_write, q[0].rw);
            check("misaligned", misaligned, exp_mis(q[0]));
        end else begin
            check("mem_write_idle", mem_write, 0);
            check("mem_read_idle", mem_read, 0);
            check("reg_write_idle", reg_write, 0);
            check("misaligned_idle", misaligned, 0);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cycle();
        bit acc_in, acc_out;
        op_t cur;
        #1;
        if (!rst) begin q.delete(); m_ready = 1; end
        compare();
        cur = '{ex_result_alu, ex_op2_data, ex_mem_write, ex_mem_read,
                ex_store_type, ex_load_type, ex_rd, ex_reg_write};
        @(posedge clk);
        acc_in  = ex_valid && m_ready;
        acc_out = (q.size() > 0) && mem_ready;
        if (!rst || flush) begin
            q.delete();
            m_ready = 1;
        end else begin
            if (acc_out) void'(q.pop_front());
            if (acc_in)  q.push_back(cur);
            m_ready = (q.size() < 2);
        end
        @(negedge clk);
    endtask

    task automatic offer(input op_t o, input bit v, input bit mr, input bit fl, output bit acc);
        drive(o, v, mr, fl);
        acc = v && m_ready && !fl && rst;
        cycle();
    endtask

    op_t ops[3];
    op_t pend;
    bit  acc;
    bit  pv;

    initial begin
        checks = 0; errors = 0; m_ready = 1;
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0), 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_reg_write", reg_write, 0);
        cycle();
        rst = 1'b1;
        cycle();
        check("rel_ex_ready", ex_ready, 1);

        // Streaming 8 SW ops at full throughput
        for (int i = 0; i < 8; i++) begin
            offer(mk(32'h100 + 4 * i, 1, 0, 2'b10, 0), 1, 1, 0, acc);
            check("stream_accept", acc, 1);
            check("stream_ready", ex_ready, 1);
        end
        drive(mk(0, 0, 0, 0, 0), 0, 1, 0);
        repeat (2) cycle();

        // Backpressure: A, B held, C waits in EX, release drains in order
        for (int i = 0; i < 3; i++) ops[i] = mk(32'h2000 + 4 * i, 1, 0, 2'b10, 0);
        offer(ops[0], 1, 0, 0, acc);
        offer(ops[1], 1, 0, 0, acc);
        check("bp_ready_low", ex_ready, 0);
        offer(ops[2], 1, 0, 0, acc);
        check("bp_c_refused", acc, 0);
        acc = 0;
        for (int i = 0; i < 10 && !acc; i++) offer(ops[2], 1, 1, 0, acc);
        check("bp_c_accepted", acc, 1);
        drive(mk(0, 0, 0, 0, 0), 0, 1, 0);
        repeat (3) cycle();

        // Reset while FULL
        offer(mk(32'h3000, 1, 0, 2'b10, 0), 1, 0, 0, acc);
        offer(mk(32'h3004, 1, 0, 2'b10, 0), 1, 0, 0, acc);
        drive(mk(0, 0, 0, 0, 0), 0, 1, 0);
        #2 rst = 1'b0;
        #1;
        check("rstfull_mem_valid", mem_valid, 0);
        check("rstfull_mem_write", mem_write, 0);
        cycle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rstfull_no_old", mem_valid, 0);
            check("rstfull_ready", ex_ready, 1);
        end

        // Flush in FULL with an incoming op, then flush in ONE with an incoming op
        offer(mk(32'h4000, 1, 0, 2'b10, 0), 1, 0, 0, acc);
        offer(mk(32'h4004, 1, 0, 2'b10, 0), 1, 0, 0, acc);
        offer(mk(32'h4008, 1, 0, 2'b10, 0), 1, 0, 1, acc);
        check("flush_full_valid", mem_valid, 0);
        check("flush_full_ready", ex_ready, 1);
        offer(mk(32'h5000, 0, 1, 0, 3'b010), 1, 0, 0, acc);
        offer(mk(32'h5004, 0, 1, 0, 3'b010), 1, 0, 1, acc);
        check("flush_one_valid", mem_valid, 0);
        drive(mk(0, 0, 0, 0, 0), 0, 1, 0);
        cycle();

        // Alignment cases
        offer(mk(32'h1001, 1, 0, 2'b01, 0), 1, 1, 0, acc);
        #1 check("align_sh_1001", misaligned, 1);
        offer(mk(32'h1002, 1, 0, 2'b10, 0), 1, 1, 0, acc);
        #1 check("align_sw_1002", misaligned, 1);
        offer(mk(32'h1003, 0, 1, 0, 3'b100), 1, 1, 0, acc);
        #1 check("align_lbu_1003", misaligned, 0);
        offer(mk(32'h1002, 1, 0, 2'b11, 0), 1, 1, 0, acc);
        #1 check("align_rsv_1002", misaligned, 1);
        drive(mk(32'h1, 1, 1, 2'b10, 3'b010), 0, 1, 0);
        cycle();
        #1;
        check("align_bubble", misaligned, 0);
        // Bubble gating
        check("bubble_mem_write", mem_write, 0);
        check("bubble_reg_write", reg_write, 0);
        cycle();

        // Randomized traffic with EX holding an op until it is taken
        pv = 0;
        pend = rand_op();
        for (int i = 0; i < 400; i++) begin
            bit fl;
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pend = rand_op();
            end
            fl = ($urandom_range(0, 24) == 0);
            offer(pend, pv, $urandom_range(0, 2) != 0, fl, acc);
            if (acc || fl) pv = 0;
        end
        drive(mk(0, 0, 0, 0, 0), 0, 1, 0);
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
